// File: rtl/bt_round_sequencer.sv
// Round sequencer for a Borrowed-Time masked cipher datapath: load, round timing, masked clears.
// Define BT_RND_PREFETCH_EN for a 2-entry random prefetch buffer (default: single entry).
module bt_round_sequencer #(
    parameter int unsigned COUNT  = 1,
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned LAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             load,
    output logic             clear,
    output logic [COUNT-1:0] rnd_out,
    output logic [5:0]       round,
    output logic             done,
    output logic             rnd_req,
    input  logic             rnd_vld,
    input  logic [COUNT-1:0] rnd_in
);

`ifdef BT_RND_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [3:0] LAST_CYC   = 4'(LAT - 1);
    localparam logic [1:0] FULL_FILL  = 2'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StWaitRnd,
        StClear,
        StDone,
        StWaitScr,
        StScrub
    } state_e;

    state_e state_q, state_d;

    logic [5:0] round_q, round_d;
    logic [3:0] cyc_q, cyc_d;

    logic [DEPTH-1:0][COUNT-1:0] buf_q, buf_d;
    logic [1:0]                  fill_q, fill_d;
    logic                        rnd_req_q;

    logic push;
    logic pop;
    logic has_entry;
    logic entry_ready;
    logic last_cyc;

    // ------------------------------------------------------------------
    // Random buffer: FIFO with the head in slot 0
    // ------------------------------------------------------------------
    assign push        = rnd_req_q & rnd_vld;
    assign pop         = (state_q == StClear) || (state_q == StScrub);
    assign has_entry   = (fill_q != 2'd0);
    // A transfer on this edge is enough to leave a wait state next cycle.
    assign entry_ready = has_entry | push;

    always_comb begin
        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + 2'd1;
        end else if (pop && !push) begin
            fill_d = fill_q - 2'd1;
        end
    end

`ifdef BT_RND_PREFETCH_EN
    logic [1:0] wr_idx;
    assign wr_idx = fill_q - {1'b0, pop};

    always_comb begin
        buf_d = buf_q;
        // Popped slots are zeroed so a consumed vector never lingers in the buffer.
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = '0;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                buf_d[0] = rnd_in;
            end else begin
                buf_d[1] = rnd_in;
            end
        end
    end
`else
    always_comb begin
        buf_d = buf_q;
        if (pop) begin
            buf_d[0] = '0;
        end
        if (push) begin
            buf_d[0] = rnd_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            fill_q    <= 2'd0;
            rnd_req_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            rnd_req_q <= (fill_d != FULL_FILL);
        end
    end

    // ------------------------------------------------------------------
    // Round and per-round cycle counters
    // ------------------------------------------------------------------
    assign last_cyc = (cyc_q == LAST_CYC);

    always_comb begin
        round_d = round_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            StLoad: begin
                round_d = 6'd0;
                cyc_d   = 4'd0;
            end
            StRun: begin
                cyc_d = cyc_q + 4'd1;
            end
            StClear: begin
                round_d = round_q + 6'd1;
                cyc_d   = 4'd0;
            end
            StScrub: begin
                round_d = 6'd0;
            end
            default: begin
                round_d = round_q;
                cyc_d   = cyc_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q <= 6'd0;
            cyc_q   <= 4'd0;
        end else begin
            round_q <= round_d;
            cyc_q   <= cyc_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (last_cyc) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = StDone;
                    end else if (has_entry) begin
                        state_d = StClear;
                    end else begin
                        state_d = StWaitRnd;
                    end
                end
            end
            StWaitRnd: begin
                if (entry_ready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StRun;
            end
            StDone: begin
                state_d = has_entry ? StScrub : StWaitScr;
            end
            StWaitScr: begin
                if (entry_ready) begin
                    state_d = StScrub;
                end
            end
            StScrub: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign busy    = (state_q != StIdle);
    assign load    = (state_q == StLoad);
    assign clear   = pop;
    assign done    = (state_q == StDone);
    assign round   = round_q;
    assign rnd_req = rnd_req_q;
    assign rnd_out = pop ? buf_q[0] : '0;

    // A clear must always consume a held entry, and the RNG may only push into free space.
    pop_has_entry: assert property (@(posedge clk) disable iff (!rst_n) pop |-> has_entry);
    push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
                                    push |-> (fill_q != FULL_FILL));

endmodule

// File: tb/tb_bt_round_sequencer.sv
// Directed bench for bt_round_sequencer (ROUNDS=4, LAT=2, COUNT=8) with a random-vector scoreboard.
module tb_bt_round_sequencer;

    localparam int unsigned COUNT  = 8;
    localparam int unsigned ROUNDS = 4;
    localparam int unsigned LAT    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             load;
    logic             clear;
    logic [COUNT-1:0] rnd_out;
    logic [5:0]       round;
    logic             done;
    logic             rnd_req;
    logic             rnd_vld;
    logic [COUNT-1:0] rnd_in;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Every vector accepted by the DUT, in capture order; each may leave exactly once.
    logic [COUNT-1:0] sb[$];

    always #5 clk = ~clk;

    bt_round_sequencer #(
        .COUNT (COUNT),
        .ROUNDS(ROUNDS),
        .LAT   (LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .load   (load),
        .clear  (clear),
        .rnd_out(rnd_out),
        .round  (round),
        .done   (done),
        .rnd_req(rnd_req),
        .rnd_vld(rnd_vld),
        .rnd_in (rnd_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m4(input int a, input int b, input int c, input int d);
        logic [31:0] m;
        m    = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
        m[c] = 1'b1;
        m[d] = 1'b1;
        return m;
    endfunction

    // 0: always valid; 1: invalid in cycles 2..8; 2: valid every third cycle
    function automatic logic vld_for(input int mode, input int c);
        if (mode == 1) return !(c >= 2 && c <= 8);
        if (mode == 2) return (c % 3 == 0);
        return 1'b1;
    endfunction

    // One clock: record transfers at the edge, check the clear vector mid-cycle.
    task automatic tick();
        logic [COUNT-1:0] exp_v;
        @(posedge clk);
        if (rst_n && rnd_req && rnd_vld) sb.push_back(rnd_in);
        @(negedge clk);
        rnd_in = rnd_in + 8'd1;
        if (clear) begin
            chk("sb_entry_at_clear", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                chk("rnd_out_at_clear", 32'(rnd_out), 32'(exp_v));
            end
        end else begin
            chk("rnd_out_zero", 32'(rnd_out), 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " load"}, 32'(load), 32'd0);
        chk({tag, " clear"}, 32'(clear), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " rnd_out"}, 32'(rnd_out), 32'd0);
        chk({tag, " round"}, 32'(round), 32'd0);
        chk({tag, " rnd_req"}, 32'(rnd_req), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start   = 1'b0;
            rnd_vld = 1'b1;
            tick();
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle clear", 32'(clear), 32'd0);
        end
    endtask

    // After reset release: request rises on the first edge, then the buffer fills.
    task automatic post_reset_fill();
        start   = 1'b0;
        rnd_vld = 1'b1;
        tick();
        chk("req_after_release", 32'(rnd_req), 32'd1);
        chk("idle_after_release", 32'(busy), 32'd0);
        tick();
`ifdef BT_RND_PREFETCH_EN
        chk("req_one_held", 32'(rnd_req), 32'd1);
        tick();
        chk("req_two_held", 32'(rnd_req), 32'd0);
`else
        chk("req_one_held", 32'(rnd_req), 32'd0);
`endif
        tick();
        chk("req_full_stays_low", 32'(rnd_req), 32'd0);
        chk("clear_after_release", 32'(clear), 32'd0);
    endtask

    // Start sampled at edge 0; cycle c follows edge c-1. Checks every output through idle_c.
    task automatic op(input string tag, input logic [31:0] clr_mask, input int done_c,
                      input int idle_c, input logic [31:0] start_mask, input int mode,
                      input int abort_c);
        int exp_r;
        start   = 1'b1;
        rnd_vld = vld_for(mode, 0);
        for (int c = 1; c <= idle_c; c++) begin
            tick();
            start   = start_mask[c];
            rnd_vld = vld_for(mode, c);
            exp_r   = 0;
            for (int b = 1; b < c; b++) begin
                if (clr_mask[b] && b < done_c) exp_r++;
            end
            if (c >= idle_c) exp_r = 0;
            chk($sformatf("%s load@%0d", tag, c), 32'(load), 32'(c == 1));
            chk($sformatf("%s clear@%0d", tag, c), 32'(clear), 32'(clr_mask[c]));
            chk($sformatf("%s done@%0d", tag, c), 32'(done), 32'(c == done_c));
            chk($sformatf("%s busy@%0d", tag, c), 32'(busy), 32'(c < idle_c));
            chk($sformatf("%s round@%0d", tag, c), 32'(round), 32'(exp_r));
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs({tag, " midop_reset"});
                rst_n = 1'b1;
                sb.delete();
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        rnd_vld = 1'b0;
        rnd_in  = 8'h10;
        #3;
        chk_reset_outputs("por");
        #9;
        rst_n = 1'b1;
        post_reset_fill();

        op("nominal", m4(4, 7, 10, 14), 13, 15, '0, 0, 0);
        idle(3);

`ifdef BT_RND_PREFETCH_EN
        op("stall", m4(4, 7, 11, 15), 14, 16, '0, 1, 0);
`else
        op("stall", m4(4, 10, 13, 17), 16, 18, '0, 1, 0);
`endif
        idle(3);

        op("busy_start", m4(4, 7, 10, 14), 13, 15, m4(3, 8, 3, 8), 0, 0);
        idle(3);

        op("abort", m4(4, 7, 10, 14), 13, 15, '0, 0, 6);
        post_reset_fill();

        op("after_reset", m4(4, 7, 10, 14), 13, 15, '0, 0, 0);
        idle(3);

`ifdef BT_RND_PREFETCH_EN
        op("sparse_rng", m4(4, 7, 10, 14), 13, 15, '0, 2, 0);
        idle(3);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
